// File: rtl/pwmrx_multi.sv
// pwmrx_multi: CHANNELS independent RC/servo PWM high-time receivers.
// Each channel synchronises its input, measures the high time in clk_in
// cycles, range-checks it, strobes update_out on acceptance and flags the
// channel stale when no pulse is accepted within TIMEOUT_CYCLES.
// Optional feature: define PWMRX_GLITCH_FILTER_EN to insert a level filter
// that ignores input changes shorter than GLITCH_CYCLES cycles.
module pwmrx_multi #(
  parameter int CHANNELS       = 4,
  parameter int SIZE           = 32,
  parameter int SYSCLK         = 25000000,
  parameter int MIN_WIDTH      = 12500,
  parameter int MAX_WIDTH      = 62500,
  parameter int TIMEOUT_CYCLES = 625000,
  parameter int GLITCH_CYCLES  = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [CHANNELS-1:0]      pulse_in,
  output logic [CHANNELS*SIZE-1:0] r_width_out,
  output logic [CHANNELS-1:0]      valid_out,
  output logic [CHANNELS-1:0]      update_out,
  output logic [CHANNELS-1:0]      timeout_out
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    HIGH     = 2'd2
  } state_t;

  if (MIN_WIDTH > MAX_WIDTH || CHANNELS < 1 || GLITCH_CYCLES < 1 || SYSCLK < 1) begin : g_bad_cfg
    $error("pwmrx_multi: invalid parameters (MIN_WIDTH > MAX_WIDTH, CHANNELS < 1, GLITCH_CYCLES < 1 or SYSCLK < 1)");
  end

`ifdef PWMRX_GLITCH_FILTER_EN
  localparam int GW = (GLITCH_CYCLES < 2) ? 1 : $clog2(GLITCH_CYCLES);
`endif

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [SIZE-1:0] sat_inc(input logic [SIZE-1:0] v);
    return (&v) ? v : v + SIZE'(1);
  endfunction

  // Acceptance window for a measured width, compared at 64 bits so that
  // limits larger than the counter range still behave sensibly.
  function automatic logic in_range(input logic [SIZE-1:0] w);
    return (64'(w) >= 64'(MIN_WIDTH)) && (64'(w) <= 64'(MAX_WIDTH));
  endfunction

  // True once the stale counter has reached the timeout threshold.
  function automatic logic tmo_reached(input logic [SIZE-1:0] v);
    return 64'(v) >= 64'(TIMEOUT_CYCLES);
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic            sync_p0, sync_p1, vld_p0, vld_p1;
    logic            s, vld_s;
    logic            lvl_p2, lvl_p3, vld_p2;
    logic            rise, fall;
    state_t          st_q, st_d;
    logic [SIZE-1:0] wcnt_q, wcnt_d;
    logic            accept;
    logic [SIZE-1:0] width_q, tmo_q, tmo_inc;
    logic            upd_q, valid_q, tmo_flag_q;

    // ---- stage p0/p1: two-flop synchroniser; vld marks real samples ----
    // Synchronise the raw pin and track how far real samples have travelled.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        sync_p0 <= 1'b0;
        sync_p1 <= 1'b0;
        vld_p0  <= 1'b0;
        vld_p1  <= 1'b0;
      end else begin
        sync_p0 <= pulse_in[ch];
        sync_p1 <= sync_p0;
        vld_p0  <= 1'b1;
        vld_p1  <= vld_p0;
      end
    end

`ifdef PWMRX_GLITCH_FILTER_EN
    logic [GW-1:0] flt_cnt;
    logic          flt_lvl, flt_vld;

    // ---- filter: level follows the input only after GLITCH_CYCLES stable samples ----
    // Count consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        flt_cnt <= '0;
        flt_lvl <= 1'b0;
        flt_vld <= 1'b0;
      end else begin
        if (vld_p1 && (sync_p1 == flt_lvl)) flt_vld <= 1'b1;
        if (sync_p1 == flt_lvl) begin
          flt_cnt <= '0;
        end else if (flt_cnt == GW'(GLITCH_CYCLES - 1)) begin
          flt_lvl <= sync_p1;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + GW'(1);
        end
      end
    end

    assign s     = flt_lvl;
    assign vld_s = flt_vld;
`else
    assign s     = sync_p1;
    assign vld_s = vld_p1;
`endif

    // ---- stage p2: edge-detect register ----
    // Register the level twice so edges come from two clean samples.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        lvl_p2 <= 1'b0;
        lvl_p3 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        lvl_p2 <= s;
        lvl_p3 <= lvl_p2;
        vld_p2 <= vld_s;
      end
    end

    assign rise = lvl_p2 & ~lvl_p3;
    assign fall = ~lvl_p2 & lvl_p3;

    // Measurement FSM state and width counter.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        st_q   <= WAIT_LOW;
        wcnt_q <= '0;
      end else begin
        st_q   <= st_d;
        wcnt_q <= wcnt_d;
      end
    end

    // Next state: a pulse is only measured after a real low sample, so a
    // line already high when reset releases is never reported.
    always_comb begin
      st_d   = st_q;
      wcnt_d = wcnt_q;
      accept = 1'b0;
      case (st_q)
        WAIT_LOW: begin
          if (vld_p2 && !lvl_p2) st_d = ARMED;
        end
        ARMED: begin
          if (rise) begin
            st_d   = HIGH;
            wcnt_d = SIZE'(1);
          end
        end
        HIGH: begin
          if (fall) begin
            st_d   = ARMED;
            accept = in_range(wcnt_q);
          end else begin
            wcnt_d = sat_inc(wcnt_q);
          end
        end
        default: st_d = WAIT_LOW;
      endcase
    end

    assign tmo_inc = sat_inc(tmo_q);

    // ---- stage p3: output register ----
    // Publish accepted widths; an acceptance overrides a coincident timeout.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        width_q    <= '0;
        upd_q      <= 1'b0;
        valid_q    <= 1'b0;
        tmo_flag_q <= 1'b0;
        tmo_q      <= '0;
      end else begin
        upd_q <= accept;
        if (accept) begin
          width_q    <= wcnt_q;
          valid_q    <= 1'b1;
          tmo_flag_q <= 1'b0;
          tmo_q      <= '0;
        end else begin
          tmo_q <= tmo_inc;
          if (tmo_reached(tmo_inc)) begin
            tmo_flag_q <= 1'b1;
            valid_q    <= 1'b0;
          end
        end
      end
    end

    assign r_width_out[ch*SIZE +: SIZE] = width_q;
    assign update_out[ch]               = upd_q;
    assign valid_out[ch]                = valid_q;
    assign timeout_out[ch]              = tmo_flag_q;
  end

endmodule

// File: tb/tb_pwmrx_multi.sv
// tb_pwmrx_multi: directed and randomised stimulus for pwmrx_multi, checked
// every cycle against a run-length model of the receiver behaviour, plus
// literal expectations for the scaled-down test plan.
module tb_pwmrx_multi;
  localparam int CH   = 4;
  localparam int SZ   = 12;
  localparam int MINW = 50;
  localparam int MAXW = 250;
  localparam int TMO  = 2500;
  localparam int GL   = 4;
  localparam int SATW = (1 << SZ) - 1;
`ifdef PWMRX_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 4;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 3;
`endif

  logic              clk_in = 1'b0;
  logic              reset_n_in = 1'b0;
  logic [CH-1:0]     pulse_in = '0;
  logic [CH*SZ-1:0]  r_width_out;
  logic [CH-1:0]     valid_out, update_out, timeout_out;

  int checks = 0;
  int errors = 0;

  pwmrx_multi #(
    .CHANNELS(CH), .SIZE(SZ), .SYSCLK(25000000), .MIN_WIDTH(MINW),
    .MAX_WIDTH(MAXW), .TIMEOUT_CYCLES(TMO), .GLITCH_CYCLES(GL)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .pulse_in(pulse_in),
    .r_width_out(r_width_out), .valid_out(valid_out),
    .update_out(update_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // model state: e counts clock edges since reset release
  int e;
  int run [CH];
  bit armed [CH], known [CH], fl [CH], lastx [CH];
  int cons [CH];
  bit pv [CH];
  int pdue [CH], pw [CH];
  int ew [CH];
  bit eupd [CH], evld [CH], etmo [CH];
  int lacc [CH];
  int ducnt [CH];
  bit mx, mf;
  int mw;

  initial begin
    for (int c = 0; c < CH; c++) ducnt[c] = 0;
    forever begin
      @(posedge clk_in);
      if (!reset_n_in) begin
        e = 0;
        for (int c = 0; c < CH; c++) begin
          run[c] = 0; armed[c] = 0; known[c] = 0; fl[c] = 0; lastx[c] = 0;
          cons[c] = 0; pv[c] = 0; pdue[c] = 0; pw[c] = 0; ew[c] = 0;
          eupd[c] = 0; evld[c] = 0; etmo[c] = 0; lacc[c] = 0;
        end
      end else begin
        e++;
        for (int c = 0; c < CH; c++) begin
          mx = pulse_in[c];
          if (FILT) begin
            if (mx == lastx[c]) cons[c]++; else cons[c] = 1;
            lastx[c] = mx;
            if (cons[c] >= GL) begin known[c] = 1; fl[c] = mx; end
            mf = fl[c];
          end else begin
            mf = mx;
            known[c] = 1;
          end
          if (!armed[c]) begin
            if (known[c] && !mf) armed[c] = 1;
            run[c] = 0;
          end else if (mf) begin
            run[c]++;
          end else begin
            if (run[c] > 0) begin
              mw = (run[c] > SATW) ? SATW : run[c];
              if (mw >= MINW && mw <= MAXW) begin
                pv[c] = 1; pdue[c] = e + LAT; pw[c] = mw;
              end
            end
            run[c] = 0;
          end
          eupd[c] = 0;
          if (pv[c] && pdue[c] == e) begin
            pv[c] = 0; ew[c] = pw[c]; eupd[c] = 1; evld[c] = 1; etmo[c] = 0; lacc[c] = e;
          end else if (e - lacc[c] >= TMO) begin
            etmo[c] = 1; evld[c] = 0;
          end
        end
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  initial begin
    logic [SZ+2:0] act, exp;
    forever begin
      @(negedge clk_in);
      for (int c = 0; c < CH; c++) begin
        act = {r_width_out[c*SZ +: SZ], valid_out[c], update_out[c], timeout_out[c]};
        if (!reset_n_in) exp = '0;
        else exp = {SZ'(ew[c]), evld[c], eupd[c], etmo[c]};
        if (update_out[c] === 1'b1) ducnt[c]++;
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL model_cmp ch%0d t=%0t: got w=%0d v=%b u=%b t=%b, want w=%0d v=%b u=%b t=%b",
                   c, $time, act[SZ+2:3], act[2], act[1], act[0], exp[SZ+2:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // count negedges until update_out[c] is seen, bounded by maxc
  task automatic wait_upd(input int c, input int maxc, output int n);
    n = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_in);
      n++;
      if (update_out[c]) break;
    end
    if (!update_out[c]) begin
      errors++; checks++;
      $display("FAIL wait_upd ch%0d: no strobe within %0d cycles", c, maxc);
    end
  endtask

  int n, base;
  int rem [CH];
  bit lv [CH];

  initial begin
    pulse_in = 4'b0010;
    reset_n_in = 1'b0;
    cyc(5);
    reset_n_in = 1'b1;
    chk("reset_width", longint'(r_width_out), 0);
    chk("reset_flags", {valid_out, update_out, timeout_out}, 0);

    // ch1 already high across reset release: partial pulse must be ignored
    cyc(120); pulse_in[1] = 1'b0; cyc(60);

    // ch0 150-cycle pulse, strobe latency from the raw falling edge
    pulse_in[0] = 1'b1; cyc(150); pulse_in[0] = 1'b0;
    wait_upd(0, 40, n);
    chk("ch0_latency", n - 1, FILT ? 4 + GL : 4);
    chk("ch0_width", r_width_out[0 +: SZ], 150);
    chk("ch0_valid", valid_out[0], 1);
    chk("model_w0", ew[0], 150);
    cyc(20);

    pulse_in[1] = 1'b1; cyc(100); pulse_in[1] = 1'b0; cyc(20);
    chk("ch1_width", r_width_out[SZ +: SZ], 100);
    chk("ch1_updates", ducnt[1], 1);
    chk("model_w1", ew[1], 100);

    // ch2 range boundaries and saturation
    pulse_in[2] = 1'b1; cyc(49); pulse_in[2] = 1'b0; cyc(30);
    chk("ch2_49_updates", ducnt[2], 0);
    chk("ch2_49_width", r_width_out[2*SZ +: SZ], 0);
    pulse_in[2] = 1'b1; cyc(50); pulse_in[2] = 1'b0; cyc(30);
    chk("ch2_50_updates", ducnt[2], 1);
    chk("ch2_50_width", r_width_out[2*SZ +: SZ], 50);
    pulse_in[2] = 1'b1; cyc(250); pulse_in[2] = 1'b0; cyc(30);
    chk("ch2_250_updates", ducnt[2], 2);
    chk("ch2_250_width", r_width_out[2*SZ +: SZ], 250);
    pulse_in[2] = 1'b1; cyc(251); pulse_in[2] = 1'b0; cyc(30);
    chk("ch2_251_updates", ducnt[2], 2);
    chk("ch2_251_width", r_width_out[2*SZ +: SZ], 250);
    pulse_in[2] = 1'b1; cyc(4200); pulse_in[2] = 1'b0; cyc(30);
    chk("ch2_sat_updates", ducnt[2], 2);
    chk("ch2_sat_width", r_width_out[2*SZ +: SZ], 250);

    // ch3 accept, then go stale exactly TIMEOUT cycles later
    pulse_in[3] = 1'b1; cyc(200); pulse_in[3] = 1'b0;
    wait_upd(3, 40, n);
    repeat (TMO - 1) @(negedge clk_in);
    chk("ch3_tmo_before", timeout_out[3], 0);
    chk("ch3_valid_before", valid_out[3], 1);
    @(negedge clk_in);
    chk("ch3_tmo_at", timeout_out[3], 1);
    chk("ch3_valid_at", valid_out[3], 0);
    chk("ch3_width_held", r_width_out[3*SZ +: SZ], 200);
    chk("model_tmo3", etmo[3], 1);
    cyc(1);
    pulse_in[3] = 1'b1; cyc(120); pulse_in[3] = 1'b0; cyc(20);
    chk("ch3_tmo_cleared", timeout_out[3], 0);
    chk("ch3_valid_again", valid_out[3], 1);
    chk("ch3_width_new", r_width_out[3*SZ +: SZ], 120);

    // all channels fall together
    pulse_in[3] = 1'b1; cyc(40); pulse_in[2] = 1'b1; cyc(40);
    pulse_in[1] = 1'b1; cyc(40); pulse_in[0] = 1'b1; cyc(80);
    pulse_in = '0;
    wait_upd(0, 40, n);
    chk("simul_strobes", update_out, 4'hF);
    chk("simul_w0", r_width_out[0 +: SZ], 80);
    chk("simul_w1", r_width_out[SZ +: SZ], 120);
    chk("simul_w2", r_width_out[2*SZ +: SZ], 160);
    chk("simul_w3", r_width_out[3*SZ +: SZ], 200);
    cyc(20);

    // 3-cycle low glitch inside a 160-cycle pulse
    base = ducnt[0];
    pulse_in[0] = 1'b1; cyc(80); pulse_in[0] = 1'b0; cyc(3);
    pulse_in[0] = 1'b1; cyc(77); pulse_in[0] = 1'b0; cyc(30);
    chk("glitch_updates", ducnt[0] - base, FILT ? 1 : 2);
    chk("glitch_width", r_width_out[0 +: SZ], FILT ? 160 : 77);

    // reset in the middle of a pulse aborts it
    base = ducnt[0];
    pulse_in[0] = 1'b1; cyc(60);
    reset_n_in = 1'b0; cyc(3);
    chk("midreset_width", longint'(r_width_out), 0);
    reset_n_in = 1'b1; cyc(40);
    pulse_in[0] = 1'b0; cyc(30);
    chk("midreset_updates", ducnt[0] - base, 0);
    chk("midreset_w0", r_width_out[0 +: SZ], 0);
    pulse_in[0] = 1'b1; cyc(100); pulse_in[0] = 1'b0; cyc(20);
    chk("post_reset_w0", r_width_out[0 +: SZ], 100);

    // randomised independent traffic on all channels
    for (int c = 0; c < CH; c++) begin rem[c] = 0; lv[c] = 1'b0; end
    repeat (30000) begin
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          lv[c] = ~lv[c];
          if (lv[c]) begin
            case ($urandom_range(0, 9))
              0, 1, 2, 3, 4, 5, 6: rem[c] = $urandom_range(MINW - 5, MAXW + 5);
              7: rem[c] = $urandom_range(1, 10);
              8: rem[c] = ($urandom_range(0, 1) != 0) ? MINW - 1 + $urandom_range(0, 1)
                                                     : MAXW + $urandom_range(0, 1);
              default: rem[c] = $urandom_range(300, 400);
            endcase
          end else begin
            rem[c] = ($urandom_range(0, 19) == 0) ? $urandom_range(2000, 3000)
                                                   : $urandom_range(1, 40);
          end
        end
        pulse_in[c] = lv[c];
        rem[c]--;
      end
      cyc(1);
    end
    pulse_in = '0;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
